fp_mul_arbiter: RTL and testbench
=================================

# fp_mul_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one combinational bfloat16 multiplier among `NUM_REQ` requesters. It accepts operand pairs over valid/ready handshakes, registers the winning operands onto the multiplier inputs, and captures the result, overflow flag and requester ID in an output register. It then returns the result to the originating requester over a per-requester valid/ready response handshake. It sits between the vector/control units and the single `fp_mul` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `EXP_WIDTH`, 8: exponent width.
- `FRAC_WIDTH`, 7: fraction width.
- Derived: `W = 1+EXP_WIDTH+FRAC_WIDTH` (operand width, `{sign,exp,frac}`); `IDW = $clog2(NUM_REQ)`.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_op1`, `req_op2`  in  NUM_REQ×W  per-requester operands, packed, requester i at `[i*W +: W]`.
- `rsp_valid`  out  NUM_REQ  result valid, one-hot or zero.
- `rsp_ready`  in  NUM_REQ  per-requester result accept.
- `rsp_res`  out  W  shared result bus.
- `rsp_ovf`  out  1  overflow flag of the result.
- `mul_op1`, `mul_op2`  out  W  operands driven to the shared multiplier.
- `mul_res`  in  W  multiplier result, combinational from `mul_op*`.
- `mul_ovf`  in  1  multiplier overflow.
- `ops_done`  out  16  count of completed response handshakes.

## Operation
**Stage S1 (issue register)**
- Holds `{v1, id1, op1, op2}`.
- `mul_op1`/`mul_op2` are driven from the S1 operands. When `v1=0` they are driven to 0.

**Stage S2 (result register)**
- Holds `{v2, id2, res, ovf}`.
- `rsp_valid[id2]=v2`; all other `rsp_valid` bits are 0.
- `rsp_res`/`rsp_ovf` are driven from S2.

**Stall logic**
- `drain2 = v2 & rsp_ready[id2]`.
- `adv1 = v1 & (!v2 | drain2)`: S1 moves into S2, capturing `mul_res`, `mul_ovf` and `id1`.
- `can_issue = !v1 | adv1`.

**Arbitration (combinational)**
- When `can_issue=1`, grant the first requester with `req_valid` high, searching from `ptr` upward with wrap modulo `NUM_REQ`.
- `req_ready[g]=1` for the granted requester only. `req_ready` may depend on `req_valid`, so requesters must not make `req_valid` depend on `req_ready`.
- On grant, S1 loads the granted operands and `id1=g`, and `ptr <= (g+1) mod NUM_REQ`.
- With no grant, `ptr` holds. If S1 advances without a new grant, `v1` clears.

**Requester obligations**
- Once `req_valid[i]` is high, `req_valid[i]` and the operands stay stable until accepted.
- The arbiter never reorders responses. Results return in grant order.

**Completion counter**
- `ops_done` increments by 1 on each `drain2`.
- It wraps from 0xFFFF to 0x0000.

**Reset**
- Asynchronous assert at any time, including mid-operation: in-flight operations are discarded with no response.
- Reset state: `v1=v2=0`, `ptr=0`, `ops_done=0`, and all data registers 0.

## Timing
**Reset values**
- `req_ready=0` (combinationally, while all `req_valid` are low).
- `rsp_valid=0`, `rsp_res=0`, `rsp_ovf=0`, `mul_op1=mul_op2=0`, `ops_done=0`.

**Latency**
- A request accepted at rising edge T appears in S1 after T and in S2 after T+1.
- `rsp_valid` is high in the cycle following edge T+1, i.e. 2 cycles of latency when no stall.

**Throughput**
- One operation per cycle while the selected `rsp_ready` stays high.

**Backpressure**
- With `rsp_ready[id2]=0`, S2 holds and S1 holds when full.
- At most 2 operations are in flight. `req_ready` stays all-zero until space frees.

**Simultaneous events**
- S2 drains, S1 advances and a new grant load all happen in the same edge. There is no bubble.

**Fairness**
- With k requesters continuously valid, each is granted once every k grants.

## Test plan
- **Single op:** after reset, requester 0 sends `0x3F80`×`0x4000` (1.0×2.0) with `rsp_ready` high → `req_ready[0]` high in the same cycle; `rsp_valid[0]` 2 cycles later with `rsp_res=0x4000`, `rsp_ovf=0`; `ops_done=1`.
- **Round robin:** all 4 requesters valid continuously; requester i sends `0x3FC0`×`0x3FC0` → grants in order 0,1,2,3,0,…; every response is `0x4010`; response order matches grant order; after 8 responses `ops_done=8`.
- **Backpressure:** requester 2 sends `0xBF80`×`0x4000` then `0x0000`×`0x4000` with `rsp_ready[2]` low for 5 cycles → response `0xC000` held stable; the third request sees `req_ready=0`. After release, responses `0xC000` then `0x0000` arrive on consecutive cycles.
- **Overflow pass-through:** requester 1 sends `0x7F00`×`0x7F00` → `rsp_valid[1]` with `rsp_ovf=1` and result exponent field all ones.
- **Reset mid-operation:** with S1 and S2 full and `rsp_ready` low, assert `rst_n` low asynchronously → `rsp_valid`, `req_ready` and `ops_done` go 0 immediately; after release, requester 0 wins first (`ptr=0`).
- **Counter wrap:** preload by running 65536 ops, or force the counter in simulation → `ops_done` reads 0x0000 after the 65536th handshake.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end and two-stage issue/result pipeline sharing one bfloat16 multiplier.
// S1 drives the multiplier combinationally; S2 holds the result until the owner accepts it.
module fp_mul_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int EXP_WIDTH  = 8,
    parameter  int FRAC_WIDTH = 7,
    localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_op1,
    input  logic [NUM_REQ*W-1:0] req_op2,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_res,
    output logic                 rsp_ovf,
    output logic [W-1:0]         mul_op1,
    output logic [W-1:0]         mul_op2,
    input  logic [W-1:0]         mul_res,
    input  logic                 mul_ovf,
    output logic [15:0]          ops_done
);

    logic           v1, v2;
    logic [IDW-1:0] id1, id2, ptr;
    logic [W-1:0]   op1, op2, res2;
    logic           ovf2;
    logic           drain2, adv1, can_issue;
    logic           gnt_any, grant;
    logic [IDW-1:0] gnt_id, ptr_nxt;

    assign drain2    = v2 & rsp_ready[id2];
    assign adv1      = v1 & (~v2 | drain2);
    assign can_issue = ~v1 | adv1;

    // First valid requester at or above ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    // No acceptance is advertised while reset holds, since it would be lost.
    assign grant   = gnt_any & can_issue & rst_n;
    assign ptr_nxt = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        rsp_valid      = '0;
        rsp_valid[id2] = v2;
    end

    assign rsp_res = res2;
    assign rsp_ovf = ovf2;
    assign mul_op1 = v1 ? op1 : '0;
    assign mul_op2 = v1 ? op2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            id1      <= '0;
            op1      <= '0;
            op2      <= '0;
            ptr      <= '0;
        end else if (grant) begin
            v1  <= 1'b1;
            id1 <= gnt_id;
            op1 <= req_op1[gnt_id*W +: W];
            op2 <= req_op2[gnt_id*W +: W];
            ptr <= ptr_nxt;
        end else if (adv1) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            id2      <= '0;
            res2     <= '0;
            ovf2     <= 1'b0;
        end else if (adv1) begin
            v2   <= 1'b1;
            id2  <= id1;
            res2 <= mul_res;
            ovf2 <= mul_ovf;
        end else if (drain2) begin
            v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ops_done <= '0;
        else if (drain2) ops_done <= ops_done + 16'd1;
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural bf16 multiplier on the mul_* port and an
// accept-to-response scoreboard; directed scenarios check handshakes and timing.
module tb_fp_mul_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_op1, req_op2;
    logic [W-1:0]   rsp_res, mul_op1, mul_op2, mul_res;
    logic           rsp_ovf, mul_ovf;
    logic [15:0]    ops_done;

    fp_mul_arbiter #(.NUM_REQ(N), .EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
        .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_res(mul_res), .mul_ovf(mul_ovf),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Truncating bf16 multiply; zero/denormal inputs give signed zero, overflow saturates to inf.
    function automatic logic [16:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [15:0] m;
        logic [6:0]  f;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'd0 || b[14:7] == 8'd0) return {1'b0, s, 15'd0};
        m = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (m[15]) begin
            f = m[14:8];
            e = e + 1;
        end else begin
            f = m[13:7];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 7'd0};
        if (e <= 0)   return {1'b0, s, 15'd0};
        return {1'b0, s, e[7:0], f};
    endfunction

    always_comb {mul_ovf, mul_res} = bf16_mul(mul_op1, mul_op2);

    int            n_chk = 0;
    int            n_err = 0;
    logic [20:0]   sb[$];
    logic [15:0]   exp_res[N];
    logic          exp_ovf[N];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, act, expv);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eo);
        req_op1[i*W +: W] = a;
        req_op2[i*W +: W] = b;
        exp_res[i] = er;
        exp_ovf[i] = eo;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        sb.delete();
        #3;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Handshakes are stable between the input update after a rising edge and the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i])
                    sb.push_back({4'(i), exp_ovf[i], exp_res[i]});
            if (|(rsp_valid & rsp_ready)) begin
                logic [3:0]  id;
                logic [20:0] e;
                id = '0;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) id = 4'(i);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp", {11'd0, id, rsp_ovf, rsp_res}, {11'd0, e});
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_op1 = '0;
        req_op2 = '0;
        for (int i = 0; i < N; i++) begin
            exp_res[i] = '0;
            exp_ovf[i] = 1'b0;
        end
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_res", 32'(rsp_res), 32'd0);
        chk("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("rst_mul_op1", 32'(mul_op1), 32'd0);
        chk("rst_mul_op2", 32'(mul_op2), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single op: 1.0 x 2.0
        step;
        set_op(0, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
        req_valid = 4'b0001;
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        step;
        req_valid = '0;
        chk("single_mul_op1", 32'(mul_op1), 32'h3F80);
        step;
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_res", 32'(rsp_res), 32'h4000);
        chk("single_rsp_ovf", 32'(rsp_ovf), 32'h0);
        step;
        chk("single_ops_done", 32'(ops_done), 32'd1);
        chk("single_idle", 32'(rsp_valid), 32'd0);

        // Round robin from ptr=0: 1.5 x 1.5 on every requester
        do_reset;
        for (int i = 0; i < N; i++) set_op(i, 16'h3FC0, 16'h3FC0, 16'h4010, 1'b0);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
            step;
        end
        req_valid = '0;
        step; step; step;
        chk("rr_ops_done", 32'(ops_done), 32'd8);

        // Backpressure on requester 2
        rsp_ready = 4'b1011;
        set_op(2, 16'hBF80, 16'h4000, 16'hC000, 1'b0);
        req_valid = 4'b0100;
        #1 chk("bp_grant1", 32'(req_ready), 32'h4);
        step;
        set_op(2, 16'h0000, 16'h4000, 16'h0000, 1'b0);
        #1 chk("bp_grant2", 32'(req_ready), 32'h4);
        step;
        set_op(2, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_full_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_valid", 32'(rsp_valid), 32'h4);
            chk("bp_hold_res", 32'(rsp_res), 32'hC000);
            step;
        end
        rsp_ready = '1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'h4);
        chk("bp_release_res", 32'(rsp_res), 32'hC000);
        step;
        req_valid = '0;
        #1;
        chk("bp_next_valid", 32'(rsp_valid), 32'h4);
        chk("bp_next_res", 32'(rsp_res), 32'h0000);
        step;
        chk("bp_third_res", 32'(rsp_res), 32'h3F80);
        step;
        chk("bp_ops_done", 32'(ops_done), 32'd11);

        // Overflow pass-through on requester 1
        set_op(1, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1);
        req_valid = 4'b0010;
        step;
        req_valid = '0;
        step;
        chk("ovf_valid", 32'(rsp_valid), 32'h2);
        chk("ovf_flag", 32'(rsp_ovf), 32'h1);
        chk("ovf_exp", 32'(rsp_res[14:7]), 32'hFF);
        step;

        // Reset with S1 and S2 full; ptr is 2 when reset hits
        rsp_ready = '0;
        set_op(1, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
        req_valid = 4'b0010;
        step;
        step;
        set_op(0, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
        set_op(3, 16'h4000, 16'h4000, 16'h4080, 1'b0);
        req_valid = 4'b1001;
        #1;
        chk("mid_full_ready", 32'(req_ready), 32'd0);
        chk("mid_full_valid", 32'(rsp_valid), 32'h2);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
        chk("mid_rst_res", 32'(rsp_res), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = '1;
        #1 chk("mid_ptr0_grant", 32'(req_ready), 32'h1);
        step;
        req_valid = 4'b1000;
        #1 chk("mid_next_grant", 32'(req_ready), 32'h8);
        step;
        req_valid = '0;
        step; step; step;
        chk("mid_ops_done", 32'(ops_done), 32'd2);

        // Counter wrap after 65536 handshakes
        do_reset;
        set_op(2, 16'h3F80, 16'h3F80, 16'h3F80, 1'b0);
        req_valid = 4'b0100;
        n = 0;
        while (ops_done != 16'hFFFF && n < 70000) begin
            step;
            n++;
        end
        chk("wrap_pre", 32'(ops_done), 32'hFFFF);
        step;
        chk("wrap", 32'(ops_done), 32'h0000);
        req_valid = '0;
        step; step; step;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
